// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation controller:
// FSM state encoding and the index-width helper.
package modexp_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_SQ   = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  // Bits needed to index v positions; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/modexp_mulmod.sv
// Combinational r = (a*b) mod n: full 2*WIDTH product followed by a
// bit-serial shift-subtract restoring reduction.
module modexp_mulmod #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] r_o
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;

  always_comb begin
    prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    rem  = '0;
    // rem < n before each shift, so one extra bit holds the shifted value.
    for (int i = 2*WIDTH-1; i >= 0; i--) begin
      rem = {rem[WIDTH-1:0], prod[i]};
      if (rem >= {1'b0, n_i}) rem = rem - {1'b0, n_i};
    end
    r_o = rem[WIDTH-1:0];
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer, one modular multiply per clock.
// Optional MODEXP_SKIP_LZ_EN starts the scan at the most significant set exponent bit.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 err
);

  localparam int IDX_W = clog2(EXP_WIDTH);

  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     mod_q, mod_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     mm_a, mm_b, mm_r;
  logic [WIDTH-1:0]     one_mod_n;
  logic [IDX_W-1:0]     start_idx;

  // PREP reduces the base (b=1); SQ squares acc; MUL multiplies by the reduced base.
  assign mm_a      = (state_q == S_PREP) ? base_q : acc_q;
  assign mm_b      = (state_q == S_PREP) ? WIDTH'(1) :
                     (state_q == S_MUL)  ? base_q : acc_q;
  assign one_mod_n = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);

  modexp_mulmod #(.WIDTH(WIDTH)) u_mulmod (
    .a_i (mm_a),
    .b_i (mm_b),
    .n_i (mod_q),
    .r_o (mm_r)
  );

`ifdef MODEXP_SKIP_LZ_EN
  always_comb begin
    start_idx = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (exp_q[i]) start_idx = IDX_W'(i);
    end
  end
`else
  assign start_idx = IDX_W'(EXP_WIDTH-1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: begin
        if (mod_q == '0) state_d = S_FIN;
`ifdef MODEXP_SKIP_LZ_EN
        else if (exp_q == '0) state_d = S_FIN;
`endif
        else state_d = S_SQ;
      end
      S_SQ: begin
        if (exp_q[idx_q])       state_d = S_MUL;
        else if (idx_q == '0)   state_d = S_FIN;
        else                    state_d = S_SQ;
      end
      S_MUL:   state_d = (idx_q == '0) ? S_FIN : S_SQ;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base;
          exp_d  = exp;
          mod_d  = modulus;
          err_d  = 1'b0;
        end
      end
      S_PREP: begin
        if (mod_q == '0) begin
          err_d    = 1'b1;
          result_d = '0;
        end else begin
          base_d = mm_r;
          acc_d  = one_mod_n;
          idx_d  = start_idx;
        end
      end
      S_SQ: begin
        acc_d = mm_r;
        // A set bit keeps idx for the following MUL, which does the decrement.
        if (!exp_q[idx_q] && idx_q != '0) idx_d = idx_q - 1'b1;
      end
      S_MUL: begin
        acc_d = mm_r;
        if (idx_q != '0) idx_d = idx_q - 1'b1;
      end
      S_FIN: begin
        result_d = err_q ? '0 : acc_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl: a right-to-left exponentiation model feeds
// expected {err,result} and latency queues that are drained on each done pulse.
module tb_modexp_ctrl;

  localparam int W  = 32;
  localparam int EW = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  base;
  logic [EW-1:0] exp;
  logic [W-1:0]  modulus;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          err;

  logic [W:0] exp_q[$];
  int         lat_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base    (base),
    .exp     (exp),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] b, input logic [EW-1:0] e,
                                       input logic [W-1:0] n);
    logic [63:0] r, x, nn;
    if (n == '0) return {1'b1, {W{1'b0}}};
    nn = {32'd0, n};
    r  = 64'd1 % nn;
    x  = {32'd0, b} % nn;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return {1'b0, r[W-1:0]};
  endfunction

  function automatic int latency(input logic [EW-1:0] e, input logic [W-1:0] n);
    int msb;
    if (n == '0) return 2;
    msb = -1;
    for (int i = 0; i < EW; i++) if (e[i]) msb = i;
`ifdef MODEXP_SKIP_LZ_EN
    if (e == '0) return 2;
    return (msb + 1) + $countones(e) + 2;
`else
    return EW + $countones(e) + 2;
`endif
  endfunction

  task automatic run_job(input logic [W-1:0] b, input logic [EW-1:0] e,
                         input logic [W-1:0] n, input bit spam);
    int         edges;
    bit         got;
    bit         busy_ok;
    logic [W:0] want;
    int         want_lat;
    exp_q.push_back(model(b, e, n));
    lat_q.push_back(latency(e, n));
    @(negedge clk);
    start = 1'b1; base = b; exp = e; modulus = n;
    @(posedge clk); #1;
    chk("err_cleared", {63'd0, err}, 64'd0);
    if (spam) begin
      base = $urandom; exp = $urandom; modulus = $urandom;
    end else start = 1'b0;
    edges   = 0;
    got     = 1'b0;
    busy_ok = busy;
    while (!got && edges < 300) begin
      @(posedge clk); #1;
      edges++;
      if (done) begin
        got   = 1'b1;
        start = 1'b0;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (spam) begin
          base = $urandom; exp = $urandom; modulus = $urandom;
        end
      end
    end
    start    = 1'b0;
    want     = exp_q.pop_front();
    want_lat = lat_q.pop_front();
    chk("busy_during_job", {63'd0, busy_ok}, 64'd1);
    chk("done_latency", 64'(edges), 64'(want_lat));
    chk("result", {32'd0, result}, {32'd0, want[W-1:0]});
    chk("err", {63'd0, err}, {63'd0, want[W]});
    chk("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int extra_done;
    rst_n = 1'b0; start = 1'b0; base = '0; exp = '0; modulus = '0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    run_job(32'd4, 32'd13, 32'd497, 1'b0);
    chk("k_4_13_497", {32'd0, result}, 64'd445);
    run_job(32'd2, 32'd10, 32'd1000, 1'b0);
    chk("k_2_10_1000", {32'd0, result}, 64'd24);
    run_job(32'd1234, 32'd7, 32'd1000, 1'b0);
    chk("k_1234_prered", {32'd0, result}, 64'd544);
    run_job(32'd234, 32'd7, 32'd1000, 1'b0);
    chk("k_234", {32'd0, result}, 64'd544);
    run_job(32'd3, 32'd0, 32'd7, 1'b0);
    chk("k_exp0", {32'd0, result}, 64'd1);
    run_job(32'd10, 32'd5, 32'd1, 1'b0);
    chk("k_n1", {32'd0, result}, 64'd0);
    run_job(32'd0, 32'd9, 32'd97, 1'b0);
    chk("k_base0", {32'd0, result}, 64'd0);
    run_job(32'd55, 32'd3, 32'd0, 1'b0);
    chk("k_err", {63'd0, err}, 64'd1);
    run_job(32'd5, 32'd3, 32'd13, 1'b0);
    chk("k_err_cleared", {32'd0, result}, 64'd8);
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);

    run_job(32'd4, 32'd13, 32'd497, 1'b1);
    chk("k_spam", {32'd0, result}, 64'd445);
    extra_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    chk("spam_single_done", 64'(extra_done), 64'd0);

    for (int k = 0; k < 6; k++)
      run_job($urandom, $urandom, $urandom | 32'h1, 1'b0);

    // Abort a job mid-scan with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; base = 32'd4; exp = 32'd13; modulus = 32'd497;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", {32'd0, result}, 64'd0);
    chk("abort_err", {63'd0, err}, 64'd0);
    extra_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    chk("abort_no_done", 64'(extra_done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_job(32'd7, 32'd23, 32'd101, 1'b0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
